// File: rtl/pool_pkg.sv
// Shared types and defaults for the 2x2 pooling window generator.
// Optional sticky overflow flag: POOL_WIN_ERR_EN.
package pool_pkg;

    localparam int POOL_DATA_W = 8;
    localparam int POOL_IMG_W  = 28;
    localparam int POOL_IMG_H  = 28;

    typedef logic [1:0] pool_win_state_t;

    localparam pool_win_state_t ROW_EVEN = 2'd0;
    localparam pool_win_state_t ROW_ODD  = 2'd1;
    localparam pool_win_state_t DONE     = 2'd2;

    typedef struct packed {
        logic [POOL_DATA_W-1:0] tl;
        logic [POOL_DATA_W-1:0] tr;
        logic [POOL_DATA_W-1:0] bl;
        logic [POOL_DATA_W-1:0] br;
    } pool_win_t;

endpackage

// File: rtl/pool_line_buf.sv
// One-row pixel store: synchronous write, asynchronous read, shared address.
module pool_line_buf
    import pool_pkg::*;
#(
    parameter int DEPTH  = POOL_IMG_W,
    parameter int DATA_W = POOL_DATA_W,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/pool_window_gen.sv
// Streaming stride-2 2x2 window generator feeding the average pooling stage.
// POOL_WIN_ERR_EN adds the sticky ovf_err output.
module pool_window_gen
    import pool_pkg::*;
#(
    parameter int IMG_W  = POOL_IMG_W,
    parameter int IMG_H  = POOL_IMG_H,
    parameter int DATA_W = POOL_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_in,
    output logic              pix_ready,
    output logic [DATA_W-1:0] win_tl,
    output logic [DATA_W-1:0] win_tr,
    output logic [DATA_W-1:0] win_bl,
    output logic [DATA_W-1:0] win_br,
    output logic              win_valid,
`ifdef POOL_WIN_ERR_EN
    output logic              ovf_err,
`endif
    output logic              frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    pool_win_state_t   state;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [DATA_W-1:0] lb_q;
    logic [DATA_W-1:0] tl_q;
    logic [DATA_W-1:0] bl_q;
    logic              xfer;
    logic              col_end;
    logic              row_end;
    logic              lb_we;

    assign pix_ready = !rst && (state != DONE);
    assign xfer      = pix_valid && pix_ready;
    assign col_end   = (col == COL_LAST);
    assign row_end   = (row == ROW_LAST);
    assign lb_we     = xfer && (state == ROW_EVEN);

    pool_line_buf #(
        .DEPTH  (IMG_W),
        .DATA_W (DATA_W),
        .AW     (CW)
    ) u_line_buf (
        .clk    (clk),
        .we     (lb_we),
        .addr   (col),
        .wdata  (pix_in),
        .rdata  (lb_q)
    );

    // An odd final row stays in ROW_EVEN, so it only fills the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ROW_EVEN;
            col   <= '0;
            row   <= '0;
        end else begin
            case (state)
                DONE: begin
                    state <= ROW_EVEN;
                    col   <= '0;
                    row   <= '0;
                end
                default: begin
                    if (xfer) begin
                        if (col_end) begin
                            col <= '0;
                            if (row_end) begin
                                row   <= '0;
                                state <= DONE;
                            end else begin
                                row   <= row + 1'b1;
                                state <= (state == ROW_EVEN) ? ROW_ODD
                                                             : ROW_EVEN;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tl_q       <= '0;
            bl_q       <= '0;
            win_tl     <= '0;
            win_tr     <= '0;
            win_bl     <= '0;
            win_br     <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= 1'b0;
            frame_done <= xfer && col_end && row_end;
            if (xfer && (state == ROW_ODD)) begin
                if (!col[0]) begin
                    bl_q <= pix_in;
                    tl_q <= lb_q;
                end else begin
                    win_tl    <= tl_q;
                    win_tr    <= lb_q;
                    win_bl    <= bl_q;
                    win_br    <= pix_in;
                    win_valid <= 1'b1;
                end
            end
        end
    end

`ifdef POOL_WIN_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_err <= 1'b0;
        end else if (pix_valid && !pix_ready) begin
            ovf_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pool_window_gen.sv
// Randomized bench: three generator instances (4x4, 28x28, 5x5) checked
// against a frame-array window model.
module tb_pool_window_gen;
    import pool_pkg::*;

    logic       clk;
    logic       rst;
    logic       pv   [3];
    logic [7:0] px   [3];
    logic       rdy  [3];
    logic [7:0] wtl  [3];
    logic [7:0] wtr  [3];
    logic [7:0] wbl  [3];
    logic [7:0] wbr  [3];
    logic       wv   [3];
    logic       fd   [3];
`ifdef POOL_WIN_ERR_EN
    logic       ovf  [3];
`endif

    int         pidx [3];
    int         prev [3];
    int         wins [3];
    logic [7:0] fr   [3][784];
    int         total;
    int         bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pool_window_gen #(.IMG_W(4), .IMG_H(4), .DATA_W(8)) u_d4 (
        .clk(clk), .rst(rst), .pix_valid(pv[0]), .pix_in(px[0]),
        .pix_ready(rdy[0]), .win_tl(wtl[0]), .win_tr(wtr[0]),
        .win_bl(wbl[0]), .win_br(wbr[0]), .win_valid(wv[0]),
`ifdef POOL_WIN_ERR_EN
        .ovf_err(ovf[0]),
`endif
        .frame_done(fd[0])
    );

    pool_window_gen #(.IMG_W(28), .IMG_H(28), .DATA_W(8)) u_d28 (
        .clk(clk), .rst(rst), .pix_valid(pv[1]), .pix_in(px[1]),
        .pix_ready(rdy[1]), .win_tl(wtl[1]), .win_tr(wtr[1]),
        .win_bl(wbl[1]), .win_br(wbr[1]), .win_valid(wv[1]),
`ifdef POOL_WIN_ERR_EN
        .ovf_err(ovf[1]),
`endif
        .frame_done(fd[1])
    );

    pool_window_gen #(.IMG_W(5), .IMG_H(5), .DATA_W(8)) u_d5 (
        .clk(clk), .rst(rst), .pix_valid(pv[2]), .pix_in(px[2]),
        .pix_ready(rdy[2]), .win_tl(wtl[2]), .win_tr(wtr[2]),
        .win_bl(wbl[2]), .win_br(wbr[2]), .win_valid(wv[2]),
`ifdef POOL_WIN_ERR_EN
        .ovf_err(ovf[2]),
`endif
        .frame_done(fd[2])
    );

    function automatic int wid(input int i);
        return (i == 0) ? 4 : (i == 1) ? 28 : 5;
    endfunction

    function automatic int npix(input int i);
        return wid(i) * wid(i);
    endfunction

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a window is due one cycle after every odd-row/odd-col
    // pixel, built from the four pixels of its 2x2 block.
    int        w;
    int        r;
    int        c;
    bit        trig;
    pool_win_t e;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            w    = wid(i);
            trig = 1'b0;
            if (prev[i] >= 0) begin
                r    = prev[i] / w;
                c    = prev[i] % w;
                trig = (r % 2 == 1) && (c % 2 == 1);
            end
            if (wv[i] === 1'b1 || trig) begin
                check("win_valid", 64'(wv[i]), 64'(trig));
            end
            if (wv[i] === 1'b1 && trig) begin
                e.tl = fr[i][(r - 1) * w + c - 1];
                e.tr = fr[i][(r - 1) * w + c];
                e.bl = fr[i][r * w + c - 1];
                e.br = fr[i][r * w + c];
                check("window", {wtl[i], wtr[i], wbl[i], wbr[i]}, e);
            end
            if (wv[i] === 1'b1) begin
                wins[i]++;
            end
            if (fd[i] === 1'b1 || prev[i] == npix(i) - 1) begin
                check("frame_done", 64'(fd[i]),
                      64'(prev[i] == npix(i) - 1));
            end
            if (!rst && (prev[i] == npix(i) - 1 || rdy[i] !== 1'b1)) begin
                check("pix_ready", 64'(rdy[i]),
                      64'(prev[i] != npix(i) - 1));
            end
            prev[i] = (pv[i] && rdy[i] === 1'b1) ? pidx[i] : -1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: pixel = index, 1: all 0xFF, 2: random
    task automatic send_frame(input int i, input int n, input int mode,
                              input int maxgap);
        int         g;
        int         tmo;
        logic       acc;
        logic [7:0] val;
        for (int k = 0; k < n; k++) begin
            g = (maxgap > 0) ? $urandom_range(maxgap, 0) : 0;
            if (g > 0) begin
                pv[i] = 1'b0;
                repeat (g) tick();
            end
            val = (mode == 0) ? k[7:0] :
                  (mode == 1) ? 8'hff : 8'($urandom);
            fr[i][k] = val;
            px[i]    = val;
            pidx[i]  = k;
            pv[i]    = 1'b1;
            tmo      = 0;
            forever begin
                acc = rdy[i];
                tick();
                if (acc) break;
                tmo++;
                if (tmo > 20) begin
                    check("accept_timeout", 64'(0), 64'(1));
                    break;
                end
            end
        end
        pv[i] = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pv[i]   = 1'b0;
            px[i]   = '0;
            pidx[i] = 0;
            prev[i] = -1;
            wins[i] = 0;
        end
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            check("rst_win_valid", 64'(wv[i]), 64'(0));
            check("rst_frame_done", 64'(fd[i]), 64'(0));
            check("rst_window", {wtl[i], wtr[i], wbl[i], wbr[i]}, 64'(0));
            check("rst_pix_ready", 64'(rdy[i]), 64'(0));
`ifdef POOL_WIN_ERR_EN
            check("rst_ovf", 64'(ovf[i]), 64'(0));
`endif
        end
        rst = 1'b0;
        tick();

        send_frame(0, 16, 0, 0);
        repeat (4) tick();
        check("wins_4x4", 64'(wins[0]), 64'(4));

        send_frame(0, 16, 0, 5);
        repeat (4) tick();
        check("wins_4x4_gaps", 64'(wins[0]), 64'(8));

        send_frame(1, 784, 1, 0);
        send_frame(1, 784, 2, 0);
        repeat (4) tick();
        check("wins_28x28", 64'(wins[1]), 64'(392));

        send_frame(2, 25, 0, 0);
        repeat (4) tick();
        check("wins_5x5", 64'(wins[2]), 64'(4));

`ifdef POOL_WIN_ERR_EN
        check("ovf_set", 64'(ovf[1]), 64'(1));
        check("ovf_clear_4x4", 64'(ovf[0]), 64'(0));
`endif

        // abort after pixel 6: the window of pixel 5 is already out
        send_frame(0, 7, 2, 2);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
`ifdef POOL_WIN_ERR_EN
        check("ovf_rst", 64'(ovf[1]), 64'(0));
`endif
        tick();
        send_frame(0, 16, 2, 3);
        repeat (4) tick();
        check("wins_abort", 64'(wins[0]), 64'(13));
        check("wins_28_final", 64'(wins[1]), 64'(392));
        check("wins_5_final", 64'(wins[2]), 64'(4));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
